// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge port used by the MEM stage.
// The stage is the master; the memory (or its bench model) is the slave.
interface mem_access_stage_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: performs loads and stores over a req/ack memory port.
// It stalls upstream while an access is outstanding and registers the WB bundle.
// An access that never gets an ack is timed out; this squashes the register write
// and raises a sticky error flag.
module mem_access_stage #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int REG_AW  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] resultALU,
    input  logic [DATA_W-1:0] storeData,
    input  logic              flush,
    output logic              stall,
    mem_access_stage_if.master mem,
    output logic              wb_valid,
    output logic              MemtoReg_wb,
    output logic              RegWrite_wb,
    output logic [REG_AW-1:0] rd_wb,
    output logic [DATA_W-1:0] dataReadMEM,
    output logic [DATA_W-1:0] resultALU_wb,
    output logic              mem_err
);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              kill_q, kill_d;
    // Bundle fields held while the memory access is in flight
    logic              l_read_q, l_read_d;
    logic              l_m2r_q, l_m2r_d;
    logic              l_rw_q, l_rw_d;
    logic [REG_AW-1:0] l_rd_q, l_rd_d;
    logic [DATA_W-1:0] l_alu_q, l_alu_d;
    // Memory bus registers
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    // WB bundle registers
    logic              wb_valid_q, wb_valid_d;
    logic              m2r_wb_q, m2r_wb_d;
    logic              rw_wb_q, rw_wb_d;
    logic [REG_AW-1:0] rd_wb_q, rd_wb_d;
    logic [DATA_W-1:0] drm_q, drm_d;
    logic [DATA_W-1:0] alu_wb_q, alu_wb_d;
    logic              mem_err_q, mem_err_d;

    logic accept, kill_now;

    assign stall    = (state_q == ACCESS);
    assign accept   = ex_valid & ~flush & (state_q == IDLE);
    // A flush in the completion cycle kills the op just like an earlier one
    assign kill_now = kill_q | flush;

    // Next-state, bus and WB bundle computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        kill_d      = kill_q;
        l_read_d    = l_read_q;
        l_m2r_d     = l_m2r_q;
        l_rw_d      = l_rw_q;
        l_rd_d      = l_rd_q;
        l_alu_d     = l_alu_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = wb_valid_q;
        m2r_wb_d    = m2r_wb_q;
        rw_wb_d     = rw_wb_q;
        rd_wb_d     = rd_wb_q;
        drm_d       = drm_q;
        alu_wb_d    = alu_wb_q;
        mem_err_d   = mem_err_q;

        case (state_q)
            IDLE: begin
                // The write enable only accompanies a valid bundle, so a
                // register is never written twice.
                wb_valid_d = 1'b0;
                rw_wb_d    = 1'b0;
                if (accept) begin
                    if (MemRead | MemWrite) begin
                        l_read_d    = MemRead & ~MemWrite;
                        l_m2r_d     = MemtoReg;
                        l_rw_d      = RegWrite;
                        l_rd_d      = rd;
                        l_alu_d     = resultALU;
                        mem_req_d   = 1'b1;
                        mem_we_d    = MemWrite;
                        mem_addr_d  = resultALU[ADDR_W-1:0];
                        mem_wdata_d = storeData;
                        cnt_d       = '0;
                        kill_d      = 1'b0;
                        state_d     = ACCESS;
                    end else begin
                        wb_valid_d = 1'b1;
                        m2r_wb_d   = MemtoReg;
                        rw_wb_d    = RegWrite;
                        rd_wb_d    = rd;
                        drm_d      = '0;
                        alu_wb_d   = resultALU;
                    end
                end
            end
            ACCESS: begin
                m2r_wb_d = l_m2r_q;
                rd_wb_d  = l_rd_q;
                alu_wb_d = l_alu_q;
                if (mem.mem_ack) begin
                    mem_req_d  = 1'b0;
                    drm_d      = l_read_q ? mem.mem_rdata : '0;
                    wb_valid_d = ~kill_now;
                    rw_wb_d    = l_rw_q & ~kill_now;
                    state_d    = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_req_d  = 1'b0;
                    mem_err_d  = 1'b1;
                    drm_d      = '0;
                    wb_valid_d = 1'b1;
                    rw_wb_d    = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    kill_d = kill_now;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears everything, including an in-flight request
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            l_read_q    <= 1'b0;
            l_m2r_q     <= 1'b0;
            l_rw_q      <= 1'b0;
            l_rd_q      <= '0;
            l_alu_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            m2r_wb_q    <= 1'b0;
            rw_wb_q     <= 1'b0;
            rd_wb_q     <= '0;
            drm_q       <= '0;
            alu_wb_q    <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            kill_q      <= kill_d;
            l_read_q    <= l_read_d;
            l_m2r_q     <= l_m2r_d;
            l_rw_q      <= l_rw_d;
            l_rd_q      <= l_rd_d;
            l_alu_q     <= l_alu_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            m2r_wb_q    <= m2r_wb_d;
            rw_wb_q     <= rw_wb_d;
            rd_wb_q     <= rd_wb_d;
            drm_q       <= drm_d;
            alu_wb_q    <= alu_wb_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign MemtoReg_wb   = m2r_wb_q;
    assign RegWrite_wb   = rw_wb_q;
    assign rd_wb         = rd_wb_q;
    assign dataReadMEM   = drm_q;
    assign resultALU_wb  = alu_wb_q;
    assign mem_err       = mem_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: expected WB bundles are queued when a bundle is
// driven and popped when wb_valid appears; bus behaviour is checked inline.
module tb_mem_access_stage;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ex_valid = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic        MemtoReg = 1'b0, RegWrite = 1'b0, flush = 1'b0;
    logic [2:0]  rd = '0;
    logic [15:0] resultALU = '0, storeData = '0;
    logic        stall, wb_valid, MemtoReg_wb, RegWrite_wb, mem_err;
    logic [2:0]  rd_wb;
    logic [15:0] dataReadMEM, resultALU_wb;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        m2r;
        logic        rw;
        logic [2:0]  rd;
        logic [15:0] drm;
        logic [15:0] alu;
    } wb_t;

    wb_t sb[$];

    mem_access_stage_if #(.ADDR_W(16), .DATA_W(16)) mif ();

    mem_access_stage #(.DATA_W(16), .ADDR_W(16), .REG_AW(3), .TIMEOUT(15)) dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .rd(rd),
        .resultALU(resultALU), .storeData(storeData), .flush(flush), .stall(stall),
        .mem(mif), .wb_valid(wb_valid), .MemtoReg_wb(MemtoReg_wb),
        .RegWrite_wb(RegWrite_wb), .rd_wb(rd_wb), .dataReadMEM(dataReadMEM),
        .resultALU_wb(resultALU_wb), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
        flush = 0; rd = '0; resultALU = '0; storeData = '0;
        mif.mem_ack = 0; mif.mem_rdata = '0;
    endtask

    task automatic drive(input logic rdv, input logic wr, input logic m2r, input logic rw,
                         input logic [2:0] r, input logic [15:0] alu, input logic [15:0] sd);
        ex_valid = 1; MemRead = rdv; MemWrite = wr; MemtoReg = m2r; RegWrite = rw;
        rd = r; resultALU = alu; storeData = sd;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 0;
        #12;
        n_cmp++;
        if ({stall, mif.mem_req, wb_valid, mem_err, RegWrite_wb} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {stall, mif.mem_req, wb_valid, mem_err, RegWrite_wb});
        end
        n_cmp++;
        if ({dataReadMEM, resultALU_wb, rd_wb, mif.mem_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_data drm=%h alu=%h rd=%0d addr=%h want 0",
                     dataReadMEM, resultALU_wb, rd_wb, mif.mem_addr);
        end
        @(negedge clock);
        reset_n = 1;
        step();
    endtask

    task automatic test_alu();
        wb_t e;
        drive(0, 0, 0, 1, 3'd3, 16'h1234, 16'h0);
        sb.push_back('{m2r:1'b0, rw:1'b1, rd:3'd3, drm:16'h0, alu:16'h1234});
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL alu_stall got=%b want=0", stall); end
        step();
        ex_valid = 0;
        n_cmp++;
        if (wb_valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL alu_latency wb_valid=%b want=1", wb_valid);
        end else begin
            e = sb.pop_front();
            n_cmp++;
            if ({MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb} !== e) begin
                n_err++;
                $display("FAIL alu_bundle got=%h want=%h",
                         {MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb}, e);
            end
        end
        step();
        n_cmp++;
        if (wb_valid !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL alu_idle wb_valid=%b stall=%b want 0 0", wb_valid, stall);
        end
    endtask

    task automatic test_back_to_back();
        wb_t e;
        logic [15:0] v;
        for (int i = 0; i < 3; i++) begin
            v = 16'h0100 + 16'(i * 16'h0111);
            drive(0, 0, i[0], 1, 3'(i + 1), v, 16'h0);
            sb.push_back('{m2r:i[0], rw:1'b1, rd:3'(i + 1), drm:16'h0, alu:v});
            step();
            n_cmp++;
            if (wb_valid !== 1'b1 || sb.size() == 0) begin
                n_err++; $display("FAIL b2b_valid[%0d] got=%b want=1", i, wb_valid);
            end else begin
                e = sb.pop_front();
                if ({MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb} !== e) begin
                    n_err++;
                    $display("FAIL b2b_bundle[%0d] got=%h want=%h", i,
                             {MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb}, e);
                end
            end
        end
        ex_valid = 0;
        step();
    endtask

    task automatic test_load();
        wb_t e;
        int stalls = 0;
        drive(1, 0, 1, 1, 3'd5, 16'h0040, 16'h0);
        sb.push_back('{m2r:1'b1, rw:1'b1, rd:3'd5, drm:16'hBEEF, alu:16'h0040});
        step();
        idle_inputs();
        n_cmp++;
        if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {1'b1, 1'b0, 16'h0040}) begin
            n_err++;
            $display("FAIL load_bus req=%b we=%b addr=%h want 1 0 0040",
                     mif.mem_req, mif.mem_we, mif.mem_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            if (stall) stalls++;
            if (k == 3) begin mif.mem_ack = 1; mif.mem_rdata = 16'hBEEF; end
            step();
            mif.mem_ack = 0;
        end
        n_cmp++;
        if (stalls != 3 || stall !== 1'b0) begin
            n_err++; $display("FAIL load_stall cycles=%0d stall=%b want 3 0", stalls, stall);
        end
        n_cmp++;
        if (wb_valid !== 1'b1 || mif.mem_req !== 1'b0 || sb.size() == 0) begin
            n_err++; $display("FAIL load_done wb_valid=%b req=%b want 1 0", wb_valid, mif.mem_req);
        end else begin
            e = sb.pop_front();
            if ({MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb} !== e) begin
                n_err++;
                $display("FAIL load_bundle got=%h want=%h",
                         {MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb}, e);
            end
        end
        step();
    endtask

    task automatic test_store();
        wb_t e;
        drive(0, 1, 0, 0, 3'd2, 16'h0010, 16'h00AA);
        sb.push_back('{m2r:1'b0, rw:1'b0, rd:3'd2, drm:16'h0, alu:16'h0010});
        step();
        idle_inputs();
        n_cmp++;
        if ({mif.mem_req, mif.mem_we, mif.mem_wdata, mif.mem_addr} !== {2'b11, 16'h00AA, 16'h0010}) begin
            n_err++;
            $display("FAIL store_bus req=%b we=%b wdata=%h addr=%h want 1 1 00aa 0010",
                     mif.mem_req, mif.mem_we, mif.mem_wdata, mif.mem_addr);
        end
        mif.mem_ack = 1;
        mif.mem_rdata = 16'h7777;
        step();
        mif.mem_ack = 0;
        n_cmp++;
        if (wb_valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL store_latency wb_valid=%b want=1", wb_valid);
        end else begin
            e = sb.pop_front();
            if ({MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb} !== e) begin
                n_err++;
                $display("FAIL store_bundle got=%h want=%h",
                         {MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb}, e);
            end
        end
        step();
    endtask

    task automatic test_timeout();
        wb_t e;
        int cycles = 0;
        drive(1, 0, 1, 1, 3'd1, 16'h0080, 16'h0);
        sb.push_back('{m2r:1'b1, rw:1'b0, rd:3'd1, drm:16'h0, alu:16'h0080});
        step();
        idle_inputs();
        for (int i = 0; i < 40; i++) begin
            if (!mif.mem_req) break;
            cycles++;
            step();
        end
        n_cmp++;
        if (cycles != 15) begin
            n_err++; $display("FAIL timeout_req_cycles got=%0d want=15", cycles);
        end
        n_cmp++;
        if (mem_err !== 1'b1 || wb_valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL timeout_flags err=%b wb_valid=%b want 1 1", mem_err, wb_valid);
        end else begin
            e = sb.pop_front();
            if ({MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb} !== e) begin
                n_err++;
                $display("FAIL timeout_bundle got=%h want=%h",
                         {MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb}, e);
            end
        end
        // A late ack outside ACCESS must be ignored
        mif.mem_ack = 1;
        step();
        mif.mem_ack = 0;
        step(); step();
        n_cmp++;
        if (mem_err !== 1'b1 || wb_valid !== 1'b0 || stall !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_sticky err=%b wb_valid=%b stall=%b want 1 0 0", mem_err, wb_valid, stall);
        end
    endtask

    task automatic test_flush();
        wb_t e;
        // Flush during ACCESS, ack two cycles later
        drive(1, 0, 1, 1, 3'd4, 16'h0050, 16'h0);
        step();
        idle_inputs();
        flush = 1;
        n_cmp++;
        if (mif.mem_req !== 1'b1) begin n_err++; $display("FAIL flush_req0 got=%b want=1", mif.mem_req); end
        step();
        flush = 0;
        n_cmp++;
        if (mif.mem_req !== 1'b1 || stall !== 1'b1) begin
            n_err++; $display("FAIL flush_req_held req=%b stall=%b want 1 1", mif.mem_req, stall);
        end
        mif.mem_ack = 1; mif.mem_rdata = 16'h1111;
        step();
        mif.mem_ack = 0;
        n_cmp++;
        if ({wb_valid, RegWrite_wb, mif.mem_req, stall} !== 4'b0) begin
            n_err++;
            $display("FAIL flush_killed wb_valid=%b rw=%b req=%b stall=%b want 0000",
                     wb_valid, RegWrite_wb, mif.mem_req, stall);
        end
        // Flush coinciding with ack
        drive(1, 0, 1, 1, 3'd7, 16'h0060, 16'h0);
        step();
        idle_inputs();
        flush = 1; mif.mem_ack = 1; mif.mem_rdata = 16'h2222;
        step();
        flush = 0; mif.mem_ack = 0;
        n_cmp++;
        if ({wb_valid, RegWrite_wb, mif.mem_req} !== 3'b0) begin
            n_err++;
            $display("FAIL flush_ack_killed wb_valid=%b rw=%b req=%b want 000", wb_valid, RegWrite_wb, mif.mem_req);
        end
        // Flush on an incoming bundle in IDLE: nothing accepted
        drive(0, 0, 0, 1, 3'd2, 16'hDEAD, 16'h0);
        flush = 1;
        step();
        idle_inputs();
        n_cmp++;
        if (wb_valid !== 1'b0 || stall !== 1'b0) begin
            n_err++; $display("FAIL flush_idle wb_valid=%b stall=%b want 0 0", wb_valid, stall);
        end
        // Next bundle goes through normally
        drive(0, 0, 0, 1, 3'd6, 16'h5A5A, 16'h0);
        sb.push_back('{m2r:1'b0, rw:1'b1, rd:3'd6, drm:16'h0, alu:16'h5A5A});
        step();
        idle_inputs();
        n_cmp++;
        if (wb_valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL flush_next wb_valid=%b want=1", wb_valid);
        end else begin
            e = sb.pop_front();
            if ({MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb} !== e) begin
                n_err++;
                $display("FAIL flush_next_bundle got=%h want=%h",
                         {MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb}, e);
            end
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        wb_t e;
        drive(1, 0, 1, 1, 3'd3, 16'h0070, 16'h0);
        step();
        idle_inputs();
        step();
        n_cmp++;
        if (mif.mem_req !== 1'b1 || stall !== 1'b1) begin
            n_err++; $display("FAIL rstmid_pre req=%b stall=%b want 1 1", mif.mem_req, stall);
        end
        #2 reset_n = 0;
        #1;
        n_cmp++;
        if ({mif.mem_req, stall, wb_valid, mem_err} !== 4'b0) begin
            n_err++;
            $display("FAIL rstmid_async req=%b stall=%b wb_valid=%b err=%b want 0000",
                     mif.mem_req, stall, wb_valid, mem_err);
        end
        step();
        reset_n = 1;
        step();
        drive(1, 0, 1, 1, 3'd3, 16'h0090, 16'h0);
        sb.push_back('{m2r:1'b1, rw:1'b1, rd:3'd3, drm:16'hCAFE, alu:16'h0090});
        step();
        idle_inputs();
        mif.mem_ack = 1; mif.mem_rdata = 16'hCAFE;
        step();
        mif.mem_ack = 0;
        n_cmp++;
        if (wb_valid !== 1'b1 || sb.size() == 0) begin
            n_err++; $display("FAIL rstmid_fresh wb_valid=%b want=1", wb_valid);
        end else begin
            e = sb.pop_front();
            if ({MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb} !== e) begin
                n_err++;
                $display("FAIL rstmid_bundle got=%h want=%h",
                         {MemtoReg_wb, RegWrite_wb, rd_wb, dataReadMEM, resultALU_wb}, e);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_timeout();
        test_flush();
        test_reset_mid_access();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
